// File: rtl/pacman_gfx_pkg.sv
// Shared screen geometry, bus widths and direction bit positions for the sprite overlay.
// Also holds the per-axis step/clamp helper used by each sprite's position register.
package pacman_gfx_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int X_BITS     = 10;
  localparam int Y_BITS     = 9;
  localparam int ADDR_BITS  = 10;
  localparam int COLOR_BITS = 12;

  // Bit positions inside a sprite's {U,D,L,R} request nibble
  localparam int DIR_R = 0;
  localparam int DIR_L = 1;
  localparam int DIR_D = 2;
  localparam int DIR_U = 3;

  typedef enum logic [1:0] {
    AX_HOLD = 2'd0,
    AX_INC  = 2'd1,
    AX_DEC  = 2'd2
  } axis_move_e;

  function automatic axis_move_e axis_move(input logic inc, input logic dec);
    axis_move_e mv;
    mv = AX_HOLD;
    if (inc && !dec) mv = AX_INC;
    if (dec && !inc) mv = AX_DEC;
    return mv;
  endfunction

  // Moving towards 0 from below STEP lands on 0; moving up saturates at maxv.
  function automatic int step_axis(input int cur, input axis_move_e mv, input int step, input int maxv);
    int r;
    r = cur;
    unique case (mv)
      AX_INC:  r = (cur + step > maxv) ? maxv : cur + step;
      AX_DEC:  r = (cur < step) ? 0 : cur - step;
      default: r = cur;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sprite_mover.sv
// One sprite's X/Y position register, stepped and screen-clamped on each frame_end.
module sprite_mover
  import pacman_gfx_pkg::*;
#(
  parameter int                SPRITE_W = 22,
  parameter int                SPRITE_H = 22,
  parameter int                STEP     = 1,
  parameter logic [X_BITS-1:0] INIT_X   = 10'd310,
  parameter logic [Y_BITS-1:0] INIT_Y   = 9'd230
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              frame_end_i,
  input  logic [3:0]        dir_i,
  input  logic              block_i,
  input  logic              en_i,
  output logic [X_BITS-1:0] pos_x_o,
  output logic [Y_BITS-1:0] pos_y_o
);

  localparam int X_MAX = SCREEN_W - SPRITE_W;
  localparam int Y_MAX = SCREEN_H - SPRITE_H;

  logic [X_BITS-1:0] pos_x_q, pos_x_d;
  logic [Y_BITS-1:0] pos_y_q, pos_y_d;

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (frame_end_i && en_i && !block_i) begin
      pos_x_d = X_BITS'(step_axis(int'(pos_x_q), axis_move(dir_i[DIR_R], dir_i[DIR_L]), STEP, X_MAX));
      pos_y_d = Y_BITS'(step_axis(int'(pos_y_q), axis_move(dir_i[DIR_D], dir_i[DIR_U]), STEP, Y_MAX));
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pos_x_q <= INIT_X;
      pos_y_q <= INIT_Y;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
    end
  end

  assign pos_x_o = pos_x_q;
  assign pos_y_o = pos_y_q;

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite overlay: hit/address stage, priority colour mux with transparency key,
// per-frame sprite-0 collision report. Two pix_en strobes from (x,y) to color_out.
module sprite_compositor
  import pacman_gfx_pkg::*;
#(
  parameter int                              NUM_SPRITES = 4,
  parameter int                              SPRITE_W    = 22,
  parameter int                              SPRITE_H    = 22,
  parameter logic [COLOR_BITS-1:0]           TRANSPARENT = 12'h000,
  parameter int                              STEP        = 1,
  parameter logic [X_BITS*NUM_SPRITES-1:0]   INIT_X      = {NUM_SPRITES{10'd310}},
  parameter logic [Y_BITS*NUM_SPRITES-1:0]   INIT_Y      = {NUM_SPRITES{9'd230}}
) (
  input  logic                                clk_i,
  input  logic                                reset_ni,
  input  logic                                pix_en_i,
  input  logic                                frame_end_i,
  input  logic                                active_i,
  input  logic [X_BITS-1:0]                   x_i,
  input  logic [Y_BITS-1:0]                   y_i,
  input  logic [4*NUM_SPRITES-1:0]            move_dir_i,
  input  logic [NUM_SPRITES-1:0]              move_block_i,
  input  logic [NUM_SPRITES-1:0]              sprite_en_i,
  output logic [ADDR_BITS*NUM_SPRITES-1:0]    sprite_addr_o,
  input  logic [COLOR_BITS*NUM_SPRITES-1:0]   sprite_color_i,
  input  logic [COLOR_BITS-1:0]               bg_color_i,
  output logic [X_BITS*NUM_SPRITES-1:0]       pos_x_o,
  output logic [Y_BITS*NUM_SPRITES-1:0]       pos_y_o,
  output logic [COLOR_BITS-1:0]               color_out_o,
  output logic [NUM_SPRITES-1:0]              collision_o,
  output logic                                collision_vld_o
);

  localparam logic [X_BITS:0]       SW_X = SPRITE_W[X_BITS:0];
  localparam logic [Y_BITS:0]       SH_Y = SPRITE_H[Y_BITS:0];
  localparam logic [ADDR_BITS-1:0]  SW_A = SPRITE_W[ADDR_BITS-1:0];

  logic [NUM_SPRITES-1:0]             hit_d, hit_q;
  logic [NUM_SPRITES-1:0]             opaque;
  logic [ADDR_BITS*NUM_SPRITES-1:0]   addr_d, addr_q;
  logic                               active_q;
  logic [COLOR_BITS-1:0]              color_d, color_q;
  logic [NUM_SPRITES-1:0]             evt_d;
  logic [NUM_SPRITES-1:0]             acc_d, acc_q;
  logic [NUM_SPRITES-1:0]             coll_d, coll_q;
  logic                               vld_q;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    logic [X_BITS-1:0] px, dx;
    logic [Y_BITS-1:0] py, dy;

    assign px = pos_x_o[g*X_BITS +: X_BITS];
    assign py = pos_y_o[g*Y_BITS +: Y_BITS];
    assign dx = x_i - px;
    assign dy = y_i - py;

    // Widened upper bound so px+SPRITE_W at the right edge cannot wrap
    assign hit_d[g] = sprite_en_i[g]
                   && (x_i >= px) && ({1'b0, x_i} < {1'b0, px} + SW_X)
                   && (y_i >= py) && ({1'b0, y_i} < {1'b0, py} + SH_Y);
    assign addr_d[g*ADDR_BITS +: ADDR_BITS] =
        hit_d[g] ? (ADDR_BITS'(dx) + SW_A * ADDR_BITS'(dy)) : '0;

    assign opaque[g] = hit_q[g] && (sprite_color_i[g*COLOR_BITS +: COLOR_BITS] != TRANSPARENT);

    sprite_mover #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .STEP     (STEP),
      .INIT_X   (INIT_X[g*X_BITS +: X_BITS]),
      .INIT_Y   (INIT_Y[g*Y_BITS +: Y_BITS])
    ) u_mover (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .frame_end_i (frame_end_i),
      .dir_i       (move_dir_i[4*g +: 4]),
      .block_i     (move_block_i[g]),
      .en_i        (sprite_en_i[g]),
      .pos_x_o     (pos_x_o[g*X_BITS +: X_BITS]),
      .pos_y_o     (pos_y_o[g*Y_BITS +: Y_BITS])
    );
  end

  always_comb begin
    color_d = bg_color_i;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) color_d = sprite_color_i[i*COLOR_BITS +: COLOR_BITS];
    end
    if (!active_q) color_d = '0;
  end

  // A stage-2 overlap seen on the frame_end clock belongs to the frame just starting
  always_comb begin
    evt_d = '0;
    for (int i = 1; i < NUM_SPRITES; i++) begin
      evt_d[i] = pix_en_i && active_q && opaque[0] && opaque[i];
    end
    acc_d  = frame_end_i ? evt_d : (acc_q | evt_d);
    coll_d = frame_end_i ? acc_q : coll_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hit_q    <= '0;
      active_q <= 1'b0;
      addr_q   <= '0;
      color_q  <= '0;
      acc_q    <= '0;
      coll_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      if (pix_en_i) begin
        hit_q    <= hit_d;
        active_q <= active_i;
        addr_q   <= addr_d;
        color_q  <= color_d;
      end
      acc_q  <= acc_d;
      coll_q <= coll_d;
      vld_q  <= frame_end_i;
    end
  end

  assign sprite_addr_o   = addr_q;
  assign color_out_o     = color_q;
  assign collision_o     = coll_q;
  assign collision_vld_o = vld_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed and randomized bench for sprite_compositor with a behavioural frame/pixel model.
module tb_sprite_compositor;

  localparam int N    = 4;
  localparam int SW   = 22;
  localparam int SH   = 22;
  localparam int XMAX = 640 - SW;
  localparam int YMAX = 480 - SH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_en = 1'b0;
  logic          frame_end = 1'b0;
  logic          active = 1'b0;
  logic [9:0]    x = '0;
  logic [8:0]    y = '0;
  logic [4*N-1:0]  move_dir = '0;
  logic [N-1:0]    move_block = '0;
  logic [N-1:0]    sprite_en = '0;
  logic [10*N-1:0] sprite_addr;
  logic [12*N-1:0] sprite_color = '0;
  logic [11:0]     bg_color = '0;
  logic [10*N-1:0] pos_x;
  logic [9*N-1:0]  pos_y;
  logic [11:0]     color_out;
  logic [N-1:0]    collision;
  logic            collision_vld;

  int total = 0;
  int bad = 0;
  bit run = 1'b1;

  always #5 clk = ~clk;

  sprite_compositor dut (
    .clk_i           (clk),
    .reset_ni        (rst_n),
    .pix_en_i        (pix_en),
    .frame_end_i     (frame_end),
    .active_i        (active),
    .x_i             (x),
    .y_i             (y),
    .move_dir_i      (move_dir),
    .move_block_i    (move_block),
    .sprite_en_i     (sprite_en),
    .sprite_addr_o   (sprite_addr),
    .sprite_color_i  (sprite_color),
    .bg_color_i      (bg_color),
    .pos_x_o         (pos_x),
    .pos_y_o         (pos_y),
    .color_out_o     (color_out),
    .collision_o     (collision),
    .collision_vld_o (collision_vld)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mx[N], my[N];
  int spx[N], spy[N];
  int s_x = 0, s_y = 0;
  bit s_act = 1'b0;
  bit [N-1:0] s_en = '0;
  int e_color = 0, e_col = 0, e_vld = 0, acc = 0;
  int e_addr[N];

  function automatic bit covers(input int px, input int py, input int qx, input int qy);
    return (qx >= px) && (qx < px + SW) && (qy >= py) && (qy < py + SH);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 310; my[i] = 230; spx[i] = 310; spy[i] = 230; e_addr[i] = 0;
    end
    s_act = 1'b0; s_en = '0; e_color = 0; e_col = 0; e_vld = 0; acc = 0;
  endtask

  task automatic m_step();
    bit op[N];
    bit found;
    int ev, dx, dy;
    ev = 0;
    e_vld = int'(frame_end);
    if (pix_en) begin
      for (int i = 0; i < N; i++)
        op[i] = s_en[i] && covers(spx[i], spy[i], s_x, s_y) && (sprite_color[i*12 +: 12] != 12'h000);
      found = 1'b0;
      e_color = int'(bg_color);
      for (int i = 0; i < N; i++)
        if (!found && op[i]) begin
          e_color = int'(sprite_color[i*12 +: 12]);
          found = 1'b1;
        end
      if (!s_act) e_color = 0;
      for (int i = 1; i < N; i++)
        if (s_act && op[0] && op[i]) ev = ev | (1 << i);
      for (int i = 0; i < N; i++) begin
        if (sprite_en[i] && covers(mx[i], my[i], int'(x), int'(y)))
          e_addr[i] = (int'(x) - mx[i]) + SW * (int'(y) - my[i]);
        else
          e_addr[i] = 0;
        spx[i] = mx[i]; spy[i] = my[i];
      end
      s_x = int'(x); s_y = int'(y); s_act = active; s_en = sprite_en;
    end
    if (frame_end) begin
      e_col = acc;
      acc = ev;
      for (int i = 0; i < N; i++)
        if (!move_block[i] && sprite_en[i]) begin
          dx = int'(move_dir[4*i]) - int'(move_dir[4*i+1]);
          dy = int'(move_dir[4*i+2]) - int'(move_dir[4*i+3]);
          mx[i] = clampi(mx[i] + dx, 0, XMAX);
          my[i] = clampi(my[i] + dy, 0, YMAX);
        end
    end else begin
      acc = acc | ev;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  always @(negedge clk) begin
    if (run) begin
      chk("color_out", int'(color_out), e_color);
      chk("collision", int'(collision), e_col);
      chk("collision_vld", int'(collision_vld), e_vld);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("sprite_addr%0d", i), int'(sprite_addr[i*10 +: 10]), e_addr[i]);
        chk($sformatf("pos_x%0d", i), int'(pos_x[i*10 +: 10]), mx[i]);
        chk($sformatf("pos_y%0d", i), int'(pos_y[i*9 +: 9]), my[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pix();
    pix_en = 1'b1;
    step();
    pix_en = 1'b0;
    repeat (3) step();
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      step();
    end
  endtask

  initial begin
    repeat (3) step();
    chk("rst pos_x0", int'(pos_x[9:0]), 310);
    chk("rst pos_y0", int'(pos_y[8:0]), 230);
    chk("rst color_out", int'(color_out), 0);
    chk("rst collision", int'(collision), 0);
    chk("rst collision_vld", int'(collision_vld), 0);
    rst_n = 1'b1;
    step();

    // Single sprite: top-left pixel, bottom-right pixel, just past the right edge
    sprite_en = 4'b0001; active = 1'b1; x = 10'd310; y = 9'd230;
    sprite_color = {12'h000, 12'h000, 12'h000, 12'hFF0}; bg_color = 12'h0AB;
    pix();
    chk("addr0 corner", int'(sprite_addr[9:0]), 0);
    pix();
    chk("color corner", int'(color_out), 'hFF0);
    x = 10'd331; y = 9'd251;
    pix();
    chk("addr0 last", int'(sprite_addr[9:0]), 483);
    x = 10'd332;
    pix();
    chk("color last", int'(color_out), 'hFF0);
    chk("addr0 miss", int'(sprite_addr[9:0]), 0);
    pix();
    chk("color miss bg", int'(color_out), 'h0AB);

    // Overlap: transparent sprite 0 shows sprite 1, then opaque sprite 0 wins and collides
    sprite_en = 4'b0011; x = 10'd315; y = 9'd235;
    sprite_color = {12'h000, 12'h000, 12'hF00, 12'h000};
    pix();
    pix();
    chk("color see-through", int'(color_out), 'hF00);
    sprite_color[11:0] = 12'h0F0;
    pix();
    chk("color priority", int'(color_out), 'h0F0);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    chk("collision vld pulse", int'(collision_vld), 1);
    chk("collision 0010", int'(collision), 'b0010);
    step();
    chk("collision vld drop", int'(collision_vld), 0);

    // Clamping at both horizontal edges
    active = 1'b0; sprite_en = 4'b0111;
    move_dir = '0; move_dir[5] = 1'b1; move_dir[8] = 1'b1;
    frames(313);
    chk("clamp left", int'(pos_x[19:10]), 0);
    chk("clamp right", int'(pos_x[29:20]), 618);

    // Cancelling requests and blocked movement
    move_dir = '0; move_dir[15:12] = 4'b0011; move_dir[3] = 1'b1;
    sprite_en = 4'b1001; move_block = 4'b0001;
    frames(2);
    chk("L+R hold", int'(pos_x[39:30]), 310);
    chk("blocked hold", int'(pos_y[8:0]), 230);
    move_block = '0; move_dir = '0;

    // Inactive video: no colour, no collision
    x = 10'd315; y = 9'd235;
    sprite_color = {12'h00F, 12'h000, 12'h000, 12'h0F0};
    frames(1);
    pix();
    pix();
    chk("inactive color", int'(color_out), 0);
    frames(1);
    chk("inactive collision", int'(collision), 0);
    active = 1'b1;
    pix();
    pix();
    chk("active color", int'(color_out), 'h0F0);
    frames(1);
    chk("collision 1000", int'(collision), 'b1000);

    // Walk sprite 0 to (100,100), then reset in mid-frame
    sprite_en = 4'b0001; move_dir = '0; move_dir[3:0] = 4'b1010;
    frames(130);
    move_dir[3:0] = 4'b0010;
    frames(80);
    chk("walk pos_x0", int'(pos_x[9:0]), 100);
    chk("walk pos_y0", int'(pos_y[8:0]), 100);
    move_dir = '0; x = 10'd105; y = 9'd105;
    pix();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid rst pos_x0", int'(pos_x[9:0]), 310);
    chk("mid rst pos_y0", int'(pos_y[8:0]), 230);
    chk("mid rst color", int'(color_out), 0);
    chk("mid rst collision", int'(collision), 0);
    chk("mid rst vld", int'(collision_vld), 0);
    step();
    rst_n = 1'b1;
    step();

    // Randomized traffic around the sprites' start area
    for (int c = 0; c < 4000; c++) begin
      pix_en     = (c % 4 == 0);
      frame_end  = ($urandom_range(0, 39) == 0);
      active     = ($urandom_range(0, 7) != 0);
      x          = 10'(270 + $urandom_range(0, 100));
      y          = 9'(190 + $urandom_range(0, 100));
      move_dir   = 16'($urandom);
      move_block = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      sprite_en  = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        sprite_color[i*12 +: 12] = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
      bg_color   = 12'($urandom);
      step();
    end
    pix_en = 1'b0; frame_end = 1'b0;
    step();
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
